// File: rtl/pio_msg_pkg.sv
// rtl/pio_msg_pkg.sv - command/response field layout, codes and channel state for the PIO timer
package pio_msg_pkg;

  localparam int TAG_BIT = 31;
  localparam int OP_MSB  = 30;
  localparam int OP_LSB  = 28;
  localparam int CH_MSB  = 27;
  localparam int CH_LSB  = 24;
  localparam int DATA_W  = 24;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_START = 3'd1;
  localparam logic [2:0] OP_STOP  = 3'd2;
  localparam logic [2:0] OP_READ  = 3'd3;
  localparam logic [2:0] OP_CLEAR = 3'd4;

  localparam logic [2:0] ST_NONE       = 3'b000;
  localparam logic [2:0] ST_ACK        = 3'b010;
  localparam logic [2:0] ST_DATA       = 3'b011;
  localparam logic [2:0] ST_ERR_BUSY   = 3'b100;
  localparam logic [2:0] ST_ERR_STATE  = 3'b101;
  localparam logic [2:0] ST_ERR_CHAN   = 3'b110;
  localparam logic [2:0] ST_ERR_OPCODE = 3'b111;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_RUNNING = 2'd1,
    CH_STOPPED = 2'd2
  } ch_state_e;

endpackage

// File: rtl/pio_cycle_channel.sv
// rtl/pio_cycle_channel.sv - one cycle-counter channel: IDLE/RUNNING/STOPPED FSM plus counter
module pio_cycle_channel
  import pio_msg_pkg::*;
#(
  parameter int CNT_W    = 24,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  output ch_state_e        state,
  output logic [CNT_W-1:0] count,
  output logic             running_next
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CH_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // start/stop/clear are one-hot by construction; a stop freezes the value reported this edge
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (clear) begin
      state_d = CH_IDLE;
      count_d = '0;
    end else if (stop) begin
      state_d = CH_STOPPED;
    end else if (start) begin
      state_d = CH_RUNNING;
      count_d = '0;
    end else if (state_q == CH_RUNNING) begin
      if (!(SATURATE && (&count_q))) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  assign state        = state_q;
  assign count        = count_q;
  assign running_next = (state_d == CH_RUNNING);

endmodule

// File: rtl/pio_multi_channel_timer.sv
// rtl/pio_multi_channel_timer.sv - tag-handshaked PIO command decoder driving N_CH cycle counters
module pio_multi_channel_timer
  import pio_msg_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 24,
  parameter bit SATURATE = 1'b1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [31:0]     inputPio,
  output logic [31:0]     outputPio,
  output logic            led,
  output logic [N_CH-1:0] running
);

  logic [31:0]     in_q;
  logic            last_tag_q;
  logic [31:0]     out_q, out_d;
  logic [N_CH-1:0] running_q;
  logic            led_q;

  ch_state_e        ch_state [N_CH];
  logic [CNT_W-1:0] ch_count [N_CH];
  logic [N_CH-1:0]  start_v, stop_v, clear_v, run_nxt;

  logic             cmd_tag;
  logic [2:0]       cmd_op;
  logic [3:0]       cmd_ch;
  logic             accept;
  logic             ch_ok;
  logic [N_CH-1:0]  sel_oh;
  ch_state_e        sel_state;
  logic [CNT_W-1:0] sel_count;
  logic [2:0]       status;
  logic [DATA_W-1:0] data;
  logic             unused_bits;

  assign cmd_tag     = in_q[TAG_BIT];
  assign cmd_op      = in_q[OP_MSB:OP_LSB];
  assign cmd_ch      = in_q[CH_MSB:CH_LSB];
  assign accept      = (cmd_tag != last_tag_q);
  assign unused_bits = ^in_q[DATA_W-1:0];

  always_comb begin
    ch_ok     = 1'b0;
    sel_oh    = '0;
    sel_state = CH_IDLE;
    sel_count = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cmd_ch == 4'(i)) begin
        ch_ok     = 1'b1;
        sel_oh[i] = 1'b1;
        sel_state = ch_state[i];
        sel_count = ch_count[i];
      end
    end
  end

  // NOP is answered even for a nonexistent channel; every other opcode checks the channel first
  always_comb begin
    out_d   = out_q;
    start_v = '0;
    stop_v  = '0;
    clear_v = '0;
    status  = ST_NONE;
    data    = '0;
    if (accept) begin
      if (cmd_op == OP_NOP) begin
        status = ST_ACK;
      end else if (!ch_ok) begin
        status = ST_ERR_CHAN;
      end else begin
        case (cmd_op)
          OP_START: begin
            if (sel_state == CH_RUNNING) begin
              status = ST_ERR_BUSY;
            end else begin
              start_v = sel_oh;
              status  = ST_ACK;
            end
          end
          OP_STOP: begin
            if (sel_state == CH_RUNNING) begin
              stop_v             = sel_oh;
              status             = ST_DATA;
              data[CNT_W-1:0]    = sel_count;
            end else begin
              status = ST_ERR_STATE;
            end
          end
          OP_READ: begin
            status          = ST_DATA;
            data[CNT_W-1:0] = sel_count;
          end
          OP_CLEAR: begin
            clear_v = sel_oh;
            status  = ST_ACK;
          end
          default: status = ST_ERR_OPCODE;
        endcase
      end
      out_d = {cmd_tag, status, cmd_ch, data};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_q       <= '0;
      last_tag_q <= 1'b0;
      out_q      <= '0;
      running_q  <= '0;
      led_q      <= 1'b0;
    end else begin
      in_q       <= inputPio;
      last_tag_q <= cmd_tag;
      out_q      <= out_d;
      running_q  <= run_nxt;
      led_q      <= |run_nxt;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pio_cycle_channel #(
      .CNT_W   (CNT_W),
      .SATURATE(SATURATE)
    ) u_ch (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start_v[g]),
      .stop        (stop_v[g]),
      .clear       (clear_v[g]),
      .state       (ch_state[g]),
      .count       (ch_count[g]),
      .running_next(run_nxt[g])
    );
  end

  assign outputPio = out_q;
  assign led       = led_q;
  assign running   = running_q;

endmodule
